// File: rtl/fft64_pkg.sv
// Shared types and constants for the FFT64 frame-regrouping blocks.
package fft64_pkg;

    localparam int DW       = 10;
    localparam int SR_DEPTH = 8;
    localparam int SEL_W    = 3;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] bitrev3(input logic [SEL_W-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

endpackage

// File: rtl/sr8_reorder_ctrl.sv
// Loads 8 samples into an external 8-entry shift register, then drains them
// through its read mux in natural or 3-bit digit-reversed order.
module sr8_reorder_ctrl #(
    parameter int DW     = fft64_pkg::DW,
    parameter bit BITREV = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          sr_ren,
    output logic [DW-1:0] sr_dinre,
    output logic [DW-1:0] sr_dinim,
    output logic [2:0]    sr_sel,
    input  logic [DW-1:0] sr_doutre,
    input  logic [DW-1:0] sr_doutim,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_last,
    output logic          busy
);
    import fft64_pkg::*;

    state_t           state, state_n;
    logic [SEL_W-1:0] wr_cnt, wr_cnt_n;
    logic [SEL_W-1:0] rd_cnt, rd_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            state  <= state_n;
            wr_cnt <= wr_cnt_n;
            rd_cnt <= rd_cnt_n;
        end
    end

    // flush overrides every transition and also suppresses the shift of a sample offered alongside it
    always_comb begin
        state_n   = state;
        wr_cnt_n  = wr_cnt;
        rd_cnt_n  = rd_cnt;
        in_ready  = 1'b0;
        sr_ren    = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    sr_ren   = 1'b1;
                    wr_cnt_n = wr_cnt + 3'd1;
                    if (wr_cnt == 3'd7) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (rd_cnt == 3'd7);
                if (out_ready) begin
                    rd_cnt_n = rd_cnt + 3'd1;
                    if (rd_cnt == 3'd7) begin
                        state_n = LOAD;
                    end
                end
            end
            default: state_n = LOAD;
        endcase
        if (flush) begin
            state_n  = LOAD;
            wr_cnt_n = '0;
            rd_cnt_n = '0;
        end
    end

    assign sr_dinre = in_re;
    assign sr_dinim = in_im;
    assign sr_sel   = BITREV ? bitrev3(rd_cnt) : rd_cnt;
    assign out_re   = sr_doutre;
    assign out_im   = sr_doutim;
    assign busy     = (state == DRAIN) || (wr_cnt != 3'd0);

endmodule

// File: tb/tb_sr8_reorder_ctrl.sv
// Bench: two controllers (reversed and natural order) each paired with a
// behavioural 8-entry shift register, checked against a frame-level model.
module tb_sr8_reorder_ctrl;

    localparam int DW = 10;
    localparam int REV[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_ready = 1'b1;

    logic          in_ready1, sr_ren1, out_valid1, out_last1, busy1;
    logic [DW-1:0] sr_dinre1, sr_dinim1, sr_doutre1, sr_doutim1, out_re1, out_im1;
    logic [2:0]    sr_sel1;
    logic          in_ready0, sr_ren0, out_valid0, out_last0, busy0;
    logic [DW-1:0] sr_dinre0, sr_dinim0, sr_doutre0, sr_doutim0, out_re0, out_im0;
    logic [2:0]    sr_sel0;

    logic [DW-1:0] sr1_re[8], sr1_im[8], sr0_re[8], sr0_im[8];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr8_reorder_ctrl #(.DW(DW), .BITREV(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_re(in_re), .in_im(in_im), .sr_ren(sr_ren1), .sr_dinre(sr_dinre1),
        .sr_dinim(sr_dinim1), .sr_sel(sr_sel1), .sr_doutre(sr_doutre1),
        .sr_doutim(sr_doutim1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_re(out_re1), .out_im(out_im1), .out_last(out_last1), .busy(busy1)
    );

    sr8_reorder_ctrl #(.DW(DW), .BITREV(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_re(in_re), .in_im(in_im), .sr_ren(sr_ren0), .sr_dinre(sr_dinre0),
        .sr_dinim(sr_dinim0), .sr_sel(sr_sel0), .sr_doutre(sr_doutre0),
        .sr_doutim(sr_doutim0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_re(out_re0), .out_im(out_im0), .out_last(out_last0), .busy(busy0)
    );

    // Behavioural shift registers: new sample enters at the top, entry 0 ends up oldest
    always @(posedge clk) begin
        if (sr_ren1) begin
            for (int i = 0; i < 7; i++) begin
                sr1_re[i] <= sr1_re[i+1];
                sr1_im[i] <= sr1_im[i+1];
            end
            sr1_re[7] <= sr_dinre1;
            sr1_im[7] <= sr_dinim1;
        end
        if (sr_ren0) begin
            for (int i = 0; i < 7; i++) begin
                sr0_re[i] <= sr0_re[i+1];
                sr0_im[i] <= sr0_im[i+1];
            end
            sr0_re[7] <= sr_dinre0;
            sr0_im[7] <= sr_dinim0;
        end
    end
    assign sr_doutre1 = sr1_re[sr_sel1];
    assign sr_doutim1 = sr1_im[sr_sel1];
    assign sr_doutre0 = sr0_re[sr_sel0];
    assign sr_doutim0 = sr0_im[sr_sel0];

    // Frame model: collects 8 samples, then expects them back in table order
    int            m_loaded;
    bit            m_drain;
    int            m_rd;
    logic [DW-1:0] m_re[8], m_im[8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loaded <= 0;
            m_drain  <= 1'b0;
            m_rd     <= 0;
        end else if (flush) begin
            m_loaded <= 0;
            m_drain  <= 1'b0;
            m_rd     <= 0;
        end else if (!m_drain && in_valid) begin
            m_re[m_loaded] <= in_re;
            m_im[m_loaded] <= in_im;
            if (m_loaded == 7) begin
                m_loaded <= 0;
                m_drain  <= 1'b1;
            end else begin
                m_loaded <= m_loaded + 1;
            end
        end else if (m_drain && out_ready) begin
            if (m_rd == 7) begin
                m_rd    <= 0;
                m_drain <= 1'b0;
            end else begin
                m_rd <= m_rd + 1;
            end
        end
    end

    logic [DW-1:0] got1[$], got0[$];
    logic [7:0]    got_last;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("in_ready1", 32'(in_ready1), 32'(!m_drain));
            checkOutput("in_ready0", 32'(in_ready0), 32'(!m_drain));
            checkOutput("out_valid1", 32'(out_valid1), 32'(m_drain));
            checkOutput("out_valid0", 32'(out_valid0), 32'(m_drain));
            checkOutput("busy1", 32'(busy1), 32'(m_drain || m_loaded != 0));
            checkOutput("busy0", 32'(busy0), 32'(m_drain || m_loaded != 0));
            checkOutput("sr_ren1", 32'(sr_ren1), 32'(!m_drain && in_valid && !flush));
            checkOutput("sr_ren0", 32'(sr_ren0), 32'(!m_drain && in_valid && !flush));
            checkOutput("sr_sel1", 32'(sr_sel1), 32'(REV[m_rd]));
            checkOutput("sr_sel0", 32'(sr_sel0), 32'(m_rd));
            checkOutput("out_last1", 32'(out_last1), 32'(m_drain && m_rd == 7));
            checkOutput("out_last0", 32'(out_last0), 32'(m_drain && m_rd == 7));
            if (!m_drain && in_valid) begin
                checkOutput("sr_dinre1", 32'(sr_dinre1), 32'(in_re));
                checkOutput("sr_dinim0", 32'(sr_dinim0), 32'(in_im));
            end
            if (m_drain) begin
                checkOutput("out_re1", 32'(out_re1), 32'(m_re[REV[m_rd]]));
                checkOutput("out_im1", 32'(out_im1), 32'(m_im[REV[m_rd]]));
                checkOutput("out_re0", 32'(out_re0), 32'(m_re[m_rd]));
                checkOutput("out_im0", 32'(out_im0), 32'(m_im[m_rd]));
                if (out_ready && !flush) begin
                    got1.push_back(out_re1);
                    got0.push_back(out_re0);
                    got_last[m_rd] = out_last1;
                end
            end
        end
    end

    // Offers samples base..base+7 (re = v, im = -v), optionally with idle gaps
    task automatic applyStimulus(input int base, input int count, input bit gaps);
        bit ok;
        int n;
        for (int k = 0; k < count; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_re    = DW'(base + k);
            in_im    = DW'(-(base + k));
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = in_ready1;
                @(posedge clk); #1;
                n++;
            end
            if (!ok) checkOutput("accept_timeout", 32'd1, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (m_drain && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_drain) checkOutput("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic checkFrame(input int base);
        checkOutput("frame_len1", 32'(got1.size()), 32'd8);
        checkOutput("frame_len0", 32'(got0.size()), 32'd8);
        if (got1.size() == 8 && got0.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                checkOutput("frame_rev", 32'(got1[k]), 32'(base + REV[k]));
                checkOutput("frame_nat", 32'(got0[k]), 32'(base + k));
            end
        end
        checkOutput("frame_last", 32'(got_last), 32'h80);
        got1.delete();
        got0.delete();
        got_last = '0;
    endtask

    initial begin
        got_last = '0;
        #2;
        checkOutput("rst_out_valid", 32'(out_valid1), 32'd0);
        checkOutput("rst_sr_sel", 32'(sr_sel1), 32'd0);
        checkOutput("rst_busy", 32'(busy1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("post_rst_in_ready", 32'(in_ready1), 32'd1);

        // Frame 0..7: first out_valid one cycle after the 8th accept
        applyStimulus(0, 8, 1'b0);
        checkOutput("first_valid", 32'(out_valid1), 32'd1);
        checkOutput("first_out", 32'(out_re1), 32'd0);
        waitDrain();
        checkFrame(0);

        // Stall 5 cycles with rd_cnt = 3
        applyStimulus(50, 8, 1'b0);
        begin
            int n = 0;
            while (!(m_drain && m_rd == 3) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_re", 32'(out_re1), 32'd56);
            checkOutput("stall_sel", 32'(sr_sel1), 32'd6);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        waitDrain();
        checkFrame(50);

        // Three back-to-back frames with random input gaps
        for (int f = 0; f < 3; f++) begin
            applyStimulus(100 + 10 * f, 8, 1'b1);
            waitDrain();
            checkFrame(100 + 10 * f);
        end

        // Flush after 5 accepts, with a sample offered alongside the flush
        applyStimulus(200, 5, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_re    = DW'(99);
        @(negedge clk);
        checkOutput("flush_ren", 32'(sr_ren1), 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_busy", 32'(busy1), 32'd0);
        applyStimulus(10, 8, 1'b0);
        waitDrain();
        checkFrame(10);

        // Reset in the middle of DRAIN
        applyStimulus(300, 8, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_out_valid", 32'(out_valid1), 32'd0);
        checkOutput("async_busy", 32'(busy1), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        got1.delete();
        got0.delete();
        got_last = '0;
        checkOutput("rst_release_ready", 32'(in_ready1), 32'd1);
        applyStimulus(400, 1, 1'b0);
        checkOutput("restart_busy", 32'(busy1), 32'd1);
        applyStimulus(401, 7, 1'b0);
        waitDrain();
        checkFrame(400);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
